// File: rtl/cgol_disp_pkg.sv
// ----------------------------------------------------------------------------
// cgol_disp_pkg: shared types and helpers for the LED matrix scanner.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cgol_disp_pkg;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  // Maps a logical "on" level to the physical pin level of a driver.
  function automatic logic apply_pol(input logic value, input logic active_low);
    return value ^ active_low;
  endfunction

endpackage : cgol_disp_pkg

`default_nettype wire

// File: rtl/frame_store.sv
// ----------------------------------------------------------------------------
// frame_store: two ROWS x COLS pixel banks; writes go to back, reads from front.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frame_store
  import cgol_disp_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [$clog2(ROWS)-1:0] wr_row_i,
  input  logic [COLS-1:0]         wr_data_i,
  input  logic                    toggle_i,
  input  logic [$clog2(ROWS)-1:0] rd_row_i,
  output logic [COLS-1:0]         rd_data_o
);

  logic [COLS-1:0] bank_q [2][ROWS];
  logic            bank_sel_q;
  logic            wr_ok;

  // Only a non power-of-two row count can see an index past the last row.
  generate
    if ((1 << $clog2(ROWS)) == ROWS) begin : g_full_index
      assign wr_ok = 1'b1;
    end else begin : g_range_check
      assign wr_ok = (32'(wr_row_i) < $unsigned(ROWS));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
    end else begin
      // Back bank is chosen from the pre-edge select, so a write coinciding
      // with a swap lands in the bank that becomes front.
      if (wr_en_i && wr_ok) begin
        bank_q[~bank_sel_q][wr_row_i] <= wr_data_i;
      end
      if (toggle_i) begin
        bank_sel_q <= ~bank_sel_q;
      end
    end
  end

  assign rd_data_o = bank_q[bank_sel_q][rd_row_i];

endmodule : frame_store

`default_nettype wire

// File: rtl/led_matrix_scanner.sv
// ----------------------------------------------------------------------------
// led_matrix_scanner: row-at-a-time LED matrix driver with blanking and
// frame-aligned front/back buffer swap.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_matrix_scanner
  import cgol_disp_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DWELL          = 1024,
  parameter int BLANK          = 16,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    frame_start,
  output logic [ROWS-1:0]         row,
  output logic [COLS-1:0]         col
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROW_W-1:0] row_idx_q;
  logic             pending_q;
  logic             swap_ack_q;
  logic             frame_start_q;
  logic [ROWS-1:0]  row_q;
  logic [COLS-1:0]  col_q;

  logic [ROWS-1:0]  row_d;
  logic [COLS-1:0]  col_d;
  logic [COLS-1:0]  front_row;
  logic             blank_done;
  logic             drive_done;
  logic             last_row;
  logic             wrap;
  logic             do_swap;

  assign blank_done = (state_q == S_BLANK) && (cnt_q == CNT_W'(BLANK - 1));
  assign drive_done = (state_q == S_DRIVE) && (cnt_q == CNT_W'(DWELL - 1));
  assign last_row   = (row_idx_q == ROW_W'(ROWS - 1));
  assign wrap       = drive_done && last_row;
  assign do_swap    = wrap && (pending_q || swap_req);

  frame_store #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_frame_store (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_row_i  (wr_row),
    .wr_data_i (wr_data),
    .toggle_i  (do_swap),
    .rd_row_i  (row_idx_q),
    .rd_data_o (front_row)
  );

  always_comb begin
    row_d = '0;
    col_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_d[r] = apply_pol((state_q == S_DRIVE) && (row_idx_q == ROW_W'(r)),
                           ROW_ACTIVE_LOW);
    end
    for (int c = 0; c < COLS; c++) begin
      col_d[c] = apply_pol((state_q == S_DRIVE) && front_row[c], COL_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      row_idx_q     <= '0;
      pending_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      row_q         <= {ROWS{ROW_ACTIVE_LOW}};
      col_q         <= {COLS{COL_ACTIVE_LOW}};
    end else begin
      // Pin outputs follow the scan state one cycle later; the frame pulses
      // are aligned to the wrap edge itself.
      row_q         <= row_d;
      col_q         <= col_d;
      swap_ack_q    <= do_swap;
      frame_start_q <= wrap;
      pending_q     <= do_swap ? 1'b0 : (pending_q || swap_req);

      case (state_q)
        S_BLANK: begin
          if (blank_done) begin
            state_q <= S_DRIVE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DRIVE: begin
          if (drive_done) begin
            state_q   <= S_BLANK;
            cnt_q     <= '0;
            row_idx_q <= last_row ? '0 : row_idx_q + ROW_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_BLANK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;
  assign row         = row_q;
  assign col         = col_q;

endmodule : led_matrix_scanner

`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
// ----------------------------------------------------------------------------
// tb_led_matrix_scanner: timeline model of the scanner checked every cycle,
// plus directed literal checks. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_led_matrix_scanner;

  localparam int B  = 2;
  localparam int D  = 4;
  localparam int P  = B + D;
  localparam int R1 = 8;
  localparam int F1 = R1 * P;
  localparam int R2 = 16;
  localparam int F2 = R2 * P;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       wr_en    = 1'b0;
  logic       swap_req = 1'b0;
  logic [2:0] wr_row   = '0;
  logic [7:0] wr_data  = '0;
  logic [7:0] row, col;
  logic       swap_ack, frame_start;
  logic [15:0] row2;
  logic [11:0] col2;
  logic        swap_ack2, frame_start2;

  int checks = 0;
  int errors = 0;

  // Model state: edge count since reset release and the two pixel banks.
  int         e     = 0;
  logic [7:0] mem [2][8];
  int         front = 0;
  bit         pend  = 1'b0;
  int         mp, mr, mr2;
  logic [7:0]  exp_row  = 8'h00;
  logic [7:0]  exp_col  = 8'hFF;
  logic        exp_ack  = 1'b0;
  logic        exp_fs   = 1'b0;
  logic [15:0] exp_row2 = 16'hFFFF;
  logic        exp_fs2  = 1'b0;

  bit check_en  = 1'b0;
  int ack_cnt   = 0;
  int fs2_first = -1;
  int fs_first, ack_first, lit_cnt, lit_first;

  logic [7:0] pat [8] = '{8'hE0, 8'h8A, 8'hEA, 8'h8E, 8'h00, 8'hEB, 8'h8C, 8'hEB};

  led_matrix_scanner #(
    .ROWS(R1), .COLS(8), .DWELL(D), .BLANK(B),
    .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .row(row), .col(col)
  );

  led_matrix_scanner #(
    .ROWS(R2), .COLS(12), .DWELL(D), .BLANK(B),
    .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dut_wide (
    .clk(clk), .reset(reset), .wr_en(1'b0), .wr_row(4'd0), .wr_data(12'd0),
    .swap_req(1'b0), .swap_ack(swap_ack2), .frame_start(frame_start2),
    .row(row2), .col(col2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, e);
    end
  endtask

  task automatic wait_e(input int n);
    while (e < n) @(negedge clk);
  endtask

  task automatic pulse_swap(input int k);
    wait_e(k - 1);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  // Outputs after edge e: edge 1+r*P+p shows row r, driven when p >= B.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      e = 0; front = 0; pend = 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < R1; r++) mem[b][r] = 8'h00;
      exp_row = 8'h00; exp_col = 8'hFF; exp_ack = 1'b0; exp_fs = 1'b0;
      exp_row2 = 16'hFFFF; exp_fs2 = 1'b0;
    end else begin
      e++;
      mp  = (e - 1) % P;
      mr  = ((e - 1) / P) % R1;
      mr2 = ((e - 1) / P) % R2;
      if (mp >= B) begin
        exp_row  = 8'd1 << mr;
        exp_col  = ~mem[front][mr];
        exp_row2 = ~(16'd1 << mr2);
      end else begin
        exp_row  = 8'h00;
        exp_col  = 8'hFF;
        exp_row2 = 16'hFFFF;
      end
      exp_fs  = (e % F1 == 0);
      exp_fs2 = (e % F2 == 0);
      exp_ack = exp_fs && (pend || swap_req);
      if (wr_en) mem[1 - front][wr_row] = wr_data;
      if (exp_ack) begin
        front = 1 - front;
        pend  = 1'b0;
      end else if (swap_req) begin
        pend = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (swap_ack === 1'b1) ack_cnt++;
    if (frame_start2 === 1'b1 && fs2_first < 0) fs2_first = e;
    if (check_en) begin
      chk("row",       32'(row),          32'(exp_row));
      chk("col",       32'(col),          32'(exp_col));
      chk("swap_ack",  32'(swap_ack),     32'(exp_ack));
      chk("frame_st",  32'(frame_start),  32'(exp_fs));
      chk("row_w",     32'(row2),         32'(exp_row2));
      chk("col_w",     32'(col2),         32'h0000_0FFF);
      chk("swap_ack_w",32'(swap_ack2),    32'h0);
      chk("frame_st_w",32'(frame_start2), 32'(exp_fs2));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete (edge %0d)", e);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("rst_row",   32'(row),         32'h00);
    chk("rst_col",   32'(col),         32'hFF);
    chk("rst_ack",   32'(swap_ack),    32'h0);
    chk("rst_fs",    32'(frame_start), 32'h0);
    reset = 1'b1;

    // Frame 1: fill the back bank, request one swap.
    wait_e(5);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_row = 3'(i); wr_data = pat[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;

    fs_first = -1; ack_first = -1; lit_cnt = 0; lit_first = -1;
    while (e < 56) begin
      @(negedge clk);
      if (frame_start === 1'b1 && fs_first < 0) fs_first = e;
      if (swap_ack === 1'b1 && ack_first < 0) ack_first = e;
      if (row === 8'h01 && col === 8'h1F) begin
        lit_cnt++;
        if (lit_first < 0) lit_first = e;
      end
    end
    chk("first_fs_edge",  32'(fs_first),  32'd48);
    chk("first_ack_edge", 32'(ack_first), 32'd48);
    chk("row0_lit_len",   32'(lit_cnt),   32'd4);
    chk("row0_lit_start", 32'(lit_first), 32'd51);

    // Frame 2: three requests coalesce into one swap at edge 96.
    pulse_swap(60);
    pulse_swap(70);
    pulse_swap(80);
    wait_e(100);
    chk("coalesce_acks", 32'(ack_cnt), 32'd2);
    chk("f3_row0_row",   32'(row),     32'h01);
    chk("f3_row0_col",   32'(col),     32'hFF);

    // Frame 3: write and swap on the same wrap edge.
    wait_e(143);
    wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hFF; swap_req = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b0;
    wait_e(166);
    chk("same_edge_row", 32'(row),     32'h08);
    chk("same_edge_col", 32'(col),     32'h00);
    chk("acks_after_f3", 32'(ack_cnt), 32'd3);

    // Frame 4: reset in the middle of row 0 drive.
    wait_e(196);
    chk("pre_rst_row", 32'(row), 32'h01);
    chk("pre_rst_col", 32'(col), 32'h1F);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_row",   32'(row),  32'h00);
    chk("async_rst_col",   32'(col),  32'hFF);
    chk("async_rst_row_w", 32'(row2), 32'h0000_FFFF);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    wait_e(3);
    chk("restart_row",   32'(row),  32'h01);
    chk("restart_col",   32'(col),  32'hFF);
    chk("restart_row_w", 32'(row2), 32'h0000_FFFE);
    pulse_swap(21);
    wait_e(52);
    chk("cleared_bank_row", 32'(row),     32'h01);
    chk("cleared_bank_col", 32'(col),     32'hFF);
    chk("acks_total",       32'(ack_cnt), 32'd4);
    chk("wide_fs_edge",     32'(fs2_first), 32'd96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_matrix_scanner

`default_nettype wire
